id_pipe_stage: RTL and testbench
================================

# id_pipe_stage

Registered, parametrised RV64I decode stage that sits between instruction fetch and execute. It decodes one instruction per cycle into operands, ALU controls and memory/branch controls for all RV64I integer opcodes, including the word forms. A valid/ready handshake on each side isolates it from fetch and execute. It also inserts one bubble on a load-use hazard and discards its contents on a pipeline flush.

## Interface
- XLEN, 64, data/address width; op2 immediates are sign-extended to XLEN.
- RST_PC, 0, reset value of out_pc.
- clk  in  1  clock; every register updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle (combinational).
- inst  in  32  instruction word.
- pc  in  XLEN  address of inst.
- rs1_r_ena / rs2_r_ena  out  1  register-file read enables (combinational from inst).
- rs1_r_addr / rs2_r_addr  out  5  read addresses; 0 when the enable is low.
- r_data1 / r_data2  in  XLEN  register-file read data, valid in the same cycle.
- flush  in  1  redirect from execute; kills the held and the incoming instruction.
- out_valid  out  1  the output register holds a live instruction.
- out_ready  in  1  execute consumes it.
- out_pc  out  XLEN  pc of the held instruction.
- out_rd  out  5  destination register.
- out_rd_wen  out  1  write enable; forced to 0 when rd==0 or the instruction is illegal.
- out_op1, out_op2  out  XLEN  ALU operands.
- out_rs2_data  out  XLEN  store data / branch compare operand.
- out_imm  out  XLEN  sign-extended immediate (branch/jump offset, store offset).
- out_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- out_is_word  out  1  32-bit operation (OP-IMM-32/OP-32); execute sign-extends the result from bit 31.
- out_mem_read, out_mem_write  out  1  load / store.
- out_mem_size  out  2  func3[1:0] (0 B, 1 H, 2 W, 3 D).
- out_mem_unsigned  out  1  func3[2] for loads.
- out_branch  out  1  conditional branch; out_br_func  out  3  func3.
- out_jump  out  2  0 none, 1 JAL, 2 JALR.
- out_illegal  out  1  unrecognised opcode or func combination.

## Operation
- Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP-IMM-32, OP, OP-32. Anything else sets out_illegal=1 and clears rd_wen and the mem/branch/jump controls. The instruction is still passed on as valid.
- Operand selection:
  - OP-IMM(-32): op1=rs1 data, op2=I-imm. Shift amount is imm[5:0] for RV64 and imm[4:0] for -32 forms. SRAI/SRAIW are selected by inst[30].
  - OP(-32): op1=rs1, op2=rs2. SUB/SRA are selected by inst[30].
  - LUI: op2=U-imm, alu PASSB.
  - AUIPC: op1=pc, op2=U-imm, ADD.
  - JAL/JALR: op1=pc, op2=4, ADD (link value). out_imm=J-imm or I-imm respectively.
  - LOAD: op1=rs1, op2=I-imm, ADD. STORE: op1=rs1, op2=S-imm, ADD, out_rs2_data=rs2.
  - BRANCH: out_imm=B-imm, out_rs2_data=rs2, op1=rs1, op2=rs2.
- Register reads: a source address of 0 yields operand 0 regardless of r_data.
- Load-use hazard (comb): out_valid & out_mem_read & out_rd!=0 & ((rs1_r_ena & rs1_r_addr==out_rd) | (rs2_r_ena & rs2_r_addr==out_rd)).
- in_ready = flush | ((~out_valid | out_ready) & ~hazard).
- Register update priority on each edge:
  1. flush → out_valid←0 (the incoming instruction is dropped);
  2. else in_valid & in_ready → load all outputs, out_valid←1;
  3. else out_valid & out_ready → out_valid←0 (this is the bubble in the hazard case);
  4. else hold.
- While out_valid & ~out_ready, every output is held stable.

## Timing
- Latency: one cycle. An instruction accepted at edge N appears on out_* immediately after edge N.
- Throughput: one instruction per cycle when out_ready=1 and there is no hazard.
- Load-use inserts exactly one bubble cycle, then the dependent instruction is accepted.
- Reset (async, any time including mid-handshake): out_valid=0, out_pc=RST_PC, and all other registered outputs 0. After reset, in_ready=1 once rst falls.
- flush together with in_valid: the incoming instruction is dropped. out_valid is 0 on the next cycle. There is no hazard stall during flush.

## Test plan
- addi x1,x2,-1 (0xFFF10093) with r_data1=5, out_ready=1 → next cycle: out_valid=1, op1=5, op2=0xFFFFFFFFFFFFFFFF, alu_op=0, rd=1, rd_wen=1.
- ld x5,0(x6) then add x7,x5,x1 back-to-back → add held (in_ready=0) for 1 cycle, out_valid=0 for 1 cycle, then add issues with rs1_r_addr=5.
- subw x3,x4,x5 with out_ready=0 for 3 cycles → outputs stable, in_ready=0, alu_op=1, is_word=1. Released on out_ready=1.
- lui x0,0x12345 → rd_wen=0. Opcode 0x7F → out_illegal=1, mem/branch/jump/rd_wen=0, out_valid=1.
- flush asserted with a valid held instruction and an incoming one → next cycle out_valid=0, and neither instruction ever appears.
- rst pulsed asynchronously mid-stream → out_valid=0 and out_pc=RST_PC immediately. The first instruction after release has 1-cycle latency.

Source files
------------

// File: rtl/id_pipe_stage.sv
// RV64I decode stage: one instruction per cycle into operands and ALU/mem/branch controls, 1-cycle latency.
// Valid/ready on both sides. The output register holds while execute stalls; one bubble on load-use; flush drops everything.
module id_pipe_stage #(
    parameter int unsigned      XLEN   = 64,
    parameter logic [XLEN-1:0]  RST_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  pc,
    output logic             rs1_r_ena,
    output logic             rs2_r_ena,
    output logic [4:0]       rs1_r_addr,
    output logic [4:0]       rs2_r_addr,
    input  logic [XLEN-1:0]  r_data1,
    input  logic [XLEN-1:0]  r_data2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic             out_rd_wen,
    output logic [XLEN-1:0]  out_op1,
    output logic [XLEN-1:0]  out_op2,
    output logic [XLEN-1:0]  out_rs2_data,
    output logic [XLEN-1:0]  out_imm,
    output logic [3:0]       out_alu_op,
    output logic             out_is_word,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic [1:0]       out_mem_size,
    output logic             out_mem_unsigned,
    output logic             out_branch,
    output logic [2:0]       out_br_func,
    output logic [1:0]       out_jump,
    output logic             out_illegal
);
    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OP32 = 7'b0111011;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    typedef struct packed {
        logic [4:0]      rd;
        logic            rd_wen;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            is_word;
        logic            mem_read;
        logic            mem_write;
        logic [1:0]      mem_size;
        logic            mem_unsigned;
        logic            branch;
        logic [2:0]      br_func;
        logic [1:0]      jump;
        logic            illegal;
    } dec_t;

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] r;
        case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            rs1_en, rs2_en, wen, ill, hazard;
    dec_t            dec_new, dec_d, dec_q;
    logic            valid_d, valid_q;
    logic [XLEN-1:0] pc_d, pc_q;

    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign shamt = XLEN'((opc == OPC_OPIMM32) ? {1'b0, inst[24:20]} : inst[25:20]);

    // Read enables depend on the opcode alone so the operand muxes below never feed back into them.
    always_comb begin
        rs1_en = 1'b0;
        rs2_en = 1'b0;
        case (opc)
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OPIMM32: rs1_en = 1'b1;
            OPC_BRANCH, OPC_STORE, OPC_OP, OPC_OP32: begin
                rs1_en = 1'b1;
                rs2_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign rs1_r_ena  = rs1_en;
    assign rs2_r_ena  = rs2_en;
    assign rs1_r_addr = rs1_en ? inst[19:15] : 5'd0;
    assign rs2_r_addr = rs2_en ? inst[24:20] : 5'd0;
    assign rs1_val    = (rs1_r_addr == 5'd0) ? '0 : r_data1;
    assign rs2_val    = (rs2_r_addr == 5'd0) ? '0 : r_data2;

    always_comb begin
        dec_new    = '0;
        dec_new.rd = inst[11:7];
        wen        = 1'b0;
        ill        = 1'b0;
        case (opc)
            OPC_LUI: begin
                wen = 1'b1;
                dec_new.op2    = imm_u;
                dec_new.alu_op = ALU_PASSB;
            end
            OPC_AUIPC: begin
                wen = 1'b1;
                dec_new.op1 = pc;
                dec_new.op2 = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                wen = 1'b1;
                ill = (opc == OPC_JALR) && (f3 != 3'b000);
                dec_new.op1  = pc;
                dec_new.op2  = XLEN'(4);
                dec_new.imm  = (opc == OPC_JAL) ? imm_j : imm_i;
                dec_new.jump = (opc == OPC_JAL) ? 2'd1 : 2'd2;
            end
            OPC_BRANCH: begin
                ill = (f3[2:1] == 2'b01);
                dec_new.op1      = rs1_val;
                dec_new.op2      = rs2_val;
                dec_new.rs2_data = rs2_val;
                dec_new.imm      = imm_b;
                dec_new.branch   = 1'b1;
                dec_new.br_func  = f3;
            end
            OPC_LOAD: begin
                wen = 1'b1;
                ill = (f3 == 3'b111);
                dec_new.op1          = rs1_val;
                dec_new.op2          = imm_i;
                dec_new.imm          = imm_i;
                dec_new.mem_read     = 1'b1;
                dec_new.mem_size     = f3[1:0];
                dec_new.mem_unsigned = f3[2];
            end
            OPC_STORE: begin
                ill = f3[2];
                dec_new.op1       = rs1_val;
                dec_new.op2       = imm_s;
                dec_new.imm       = imm_s;
                dec_new.rs2_data  = rs2_val;
                dec_new.mem_write = 1'b1;
                dec_new.mem_size  = f3[1:0];
            end
            OPC_OPIMM, OPC_OPIMM32: begin
                wen = 1'b1;
                dec_new.is_word = (opc == OPC_OPIMM32);
                dec_new.op1     = rs1_val;
                dec_new.op2     = (f3[1:0] == 2'b01) ? shamt : imm_i;
                dec_new.alu_op  = alu_sel(f3, inst[30] & (f3 == 3'b101));
                if (f3 == 3'b001)
                    ill = dec_new.is_word ? (f7 != 7'd0) : (inst[31:26] != 6'd0);
                else if (f3 == 3'b101)
                    ill = dec_new.is_word ? (f7 != 7'd0 && f7 != 7'b0100000)
                                          : (inst[31:26] != 6'd0 && inst[31:26] != 6'b010000);
                else
                    ill = dec_new.is_word && (f3 != 3'b000);
            end
            OPC_OP, OPC_OP32: begin
                wen = 1'b1;
                dec_new.is_word = (opc == OPC_OP32);
                dec_new.op1     = rs1_val;
                dec_new.op2     = rs2_val;
                dec_new.alu_op  = alu_sel(f3, inst[30]);
                if (f7 == 7'd0)
                    ill = dec_new.is_word && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
                else if (f7 == 7'b0100000)
                    ill = !(f3 == 3'b000 || f3 == 3'b101);
                else
                    ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        // Illegal instructions still flow downstream but must have no side effects.
        if (ill) begin
            dec_new.mem_read  = 1'b0;
            dec_new.mem_write = 1'b0;
            dec_new.branch    = 1'b0;
            dec_new.jump      = 2'd0;
        end
        dec_new.illegal = ill;
        dec_new.rd_wen  = wen & ~ill & (inst[11:7] != 5'd0);
    end

    assign hazard = valid_q & dec_q.mem_read & (dec_q.rd != 5'd0) &
                    ((rs1_r_ena & (rs1_r_addr == dec_q.rd)) | (rs2_r_ena & (rs2_r_addr == dec_q.rd)));
    assign in_ready = flush | ((~valid_q | out_ready) & ~hazard);

    always_comb begin
        valid_d = valid_q;
        dec_d   = dec_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_valid & in_ready) begin
            valid_d = 1'b1;
            dec_d   = dec_new;
            pc_d    = pc;
        end else if (valid_q & out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= RST_PC;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            dec_q   <= dec_d;
        end
    end

    assign out_valid        = valid_q;
    assign out_pc           = pc_q;
    assign out_rd           = dec_q.rd;
    assign out_rd_wen       = dec_q.rd_wen;
    assign out_op1          = dec_q.op1;
    assign out_op2          = dec_q.op2;
    assign out_rs2_data     = dec_q.rs2_data;
    assign out_imm          = dec_q.imm;
    assign out_alu_op       = dec_q.alu_op;
    assign out_is_word      = dec_q.is_word;
    assign out_mem_read     = dec_q.mem_read;
    assign out_mem_write    = dec_q.mem_write;
    assign out_mem_size     = dec_q.mem_size;
    assign out_mem_unsigned = dec_q.mem_unsigned;
    assign out_branch       = dec_q.branch;
    assign out_br_func      = dec_q.br_func;
    assign out_jump         = dec_q.jump;
    assign out_illegal      = dec_q.illegal;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage: hand-encoded instructions with hand-computed decode results.
module tb_id_pipe_stage;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] inst;
    logic [63:0] pc, r_data1, r_data2;
    logic        rs1_r_ena, rs2_r_ena;
    logic [4:0]  rs1_r_addr, rs2_r_addr, out_rd;
    logic [63:0] out_pc, out_op1, out_op2, out_rs2_data, out_imm;
    logic        out_rd_wen, out_is_word, out_mem_read, out_mem_write, out_mem_unsigned;
    logic        out_branch, out_illegal;
    logic [3:0]  out_alu_op;
    logic [1:0]  out_mem_size, out_jump;
    logic [2:0]  out_br_func;

    int checks = 0;
    int errors = 0;

    id_pipe_stage #(.XLEN(64), .RST_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
        .rs1_r_ena(rs1_r_ena), .rs2_r_ena(rs2_r_ena), .rs1_r_addr(rs1_r_addr), .rs2_r_addr(rs2_r_addr),
        .r_data1(r_data1), .r_data2(r_data2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_op1(out_op1), .out_op2(out_op2),
        .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_alu_op(out_alu_op), .out_is_word(out_is_word),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_mem_size(out_mem_size),
        .out_mem_unsigned(out_mem_unsigned), .out_branch(out_branch), .out_br_func(out_br_func),
        .out_jump(out_jump), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [63:0] p, input logic [63:0] d1, input logic [63:0] d2);
        in_valid = 1'b1;
        inst     = i;
        pc       = p;
        r_data1  = d1;
        r_data2  = d2;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; inst = 32'h0; pc = 64'h0;
        r_data1 = 64'h0; r_data2 = 64'h0; flush = 1'b0; out_ready = 1'b1;
        #3;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc", out_pc, RST_PC);
        chk("rst_op1", out_op1, 64'd0);
        chk("rst_rd_wen", 64'(out_rd_wen), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // addi x1,x2,-1
        drive(32'hFFF1_0093, 64'h100, 64'd5, 64'd0);
        #1;
        chk("addi_rs1_ena", 64'(rs1_r_ena), 64'd1);
        chk("addi_rs1_addr", 64'(rs1_r_addr), 64'd2);
        chk("addi_rs2_addr", 64'(rs2_r_addr), 64'd0);
        tick();
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_pc", out_pc, 64'h100);
        chk("addi_op1", out_op1, 64'd5);
        chk("addi_op2", out_op2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_alu", 64'(out_alu_op), 64'd0);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_wen", 64'(out_rd_wen), 64'd1);

        // ld x5,0(x6) followed by dependent add x7,x5,x1
        drive(32'h0003_3283, 64'h104, 64'h2000, 64'd0);
        tick();
        chk("ld_valid", 64'(out_valid), 64'd1);
        chk("ld_mem_read", 64'(out_mem_read), 64'd1);
        chk("ld_size", 64'(out_mem_size), 64'd3);
        chk("ld_op1", out_op1, 64'h2000);
        chk("ld_rd", 64'(out_rd), 64'd5);
        drive(32'h0012_83B3, 64'h108, 64'h11, 64'h22);
        #1;
        chk("hazard_in_ready", 64'(in_ready), 64'd0);
        chk("hazard_rs1_addr", 64'(rs1_r_addr), 64'd5);
        tick();
        chk("bubble_valid", 64'(out_valid), 64'd0);
        chk("bubble_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_pc", out_pc, 64'h108);
        chk("add_op1", out_op1, 64'h11);
        chk("add_op2", out_op2, 64'h22);
        chk("add_rd", 64'(out_rd), 64'd7);
        chk("add_mem_read", 64'(out_mem_read), 64'd0);

        // subw x3,x4,x5 then stall for 3 cycles
        drive(32'h4052_01BB, 64'h10C, 64'h30, 64'h10);
        tick();
        chk("subw_alu", 64'(out_alu_op), 64'd1);
        chk("subw_word", 64'(out_is_word), 64'd1);
        chk("subw_op1", out_op1, 64'h30);
        chk("subw_rd", 64'(out_rd), 64'd3);
        out_ready = 1'b0;
        drive(32'h1234_5037, 64'h110, 64'hDEAD, 64'hBEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_pc", out_pc, 64'h10C);
            chk("stall_op1", out_op1, 64'h30);
            chk("stall_alu", 64'(out_alu_op), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        tick();
        // lui x0,0x12345
        chk("lui_pc", out_pc, 64'h110);
        chk("lui_wen", 64'(out_rd_wen), 64'd0);
        chk("lui_op2", out_op2, 64'h1234_5000);
        chk("lui_alu", 64'(out_alu_op), 64'd10);

        // opcode 0x7F with rd=31
        drive(32'hFFFF_FFFF, 64'h114, 64'd0, 64'd0);
        tick();
        chk("ill_valid", 64'(out_valid), 64'd1);
        chk("ill_flag", 64'(out_illegal), 64'd1);
        chk("ill_wen", 64'(out_rd_wen), 64'd0);
        chk("ill_mem", 64'({out_mem_read, out_mem_write}), 64'd0);
        chk("ill_br_jmp", 64'({out_branch, out_jump}), 64'd0);

        // flush with held and incoming instruction
        out_ready = 1'b0;
        drive(32'h0050_0093, 64'h118, 64'h99, 64'd0);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("flush_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("flush_valid2", 64'(out_valid), 64'd0);

        // addi x1,x0,5: x0 source reads as zero
        out_ready = 1'b1;
        drive(32'h0050_0093, 64'h118, 64'h99, 64'd0);
        tick();
        chk("x0_valid", 64'(out_valid), 64'd1);
        chk("x0_op1", out_op1, 64'd0);
        chk("x0_op2", out_op2, 64'd5);

        // srai x1,x1,63
        drive(32'h43F0_D093, 64'h11C, 64'h8000_0000_0000_0000, 64'd0);
        tick();
        chk("srai_alu", 64'(out_alu_op), 64'd7);
        chk("srai_op2", out_op2, 64'd63);
        chk("srai_op1", out_op1, 64'h8000_0000_0000_0000);

        // jal x1,+8
        drive(32'h0080_00EF, 64'h200, 64'd0, 64'd0);
        tick();
        chk("jal_jump", 64'(out_jump), 64'd1);
        chk("jal_op1", out_op1, 64'h200);
        chk("jal_op2", out_op2, 64'd4);
        chk("jal_imm", out_imm, 64'd8);
        chk("jal_wen", 64'(out_rd_wen), 64'd1);

        // asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_pc", out_pc, RST_PC);
        chk("arst_jump", 64'(out_jump), 64'd0);
        #1 rst = 1'b0;
        // sd x2,16(x3)
        drive(32'h0021_B823, 64'h300, 64'h1000, 64'hABCD);
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("sd_valid", 64'(out_valid), 64'd1);
        chk("sd_pc", out_pc, 64'h300);
        chk("sd_mem_write", 64'(out_mem_write), 64'd1);
        chk("sd_op1", out_op1, 64'h1000);
        chk("sd_op2", out_op2, 64'd16);
        chk("sd_rs2_data", out_rs2_data, 64'hABCD);
        chk("sd_wen", 64'(out_rd_wen), 64'd0);

        // bne x1,x2,-8
        drive(32'hFE20_9CE3, 64'h304, 64'd7, 64'd9);
        tick();
        chk("bne_branch", 64'(out_branch), 64'd1);
        chk("bne_func", 64'(out_br_func), 64'd1);
        chk("bne_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("bne_rs2_data", out_rs2_data, 64'd9);
        chk("bne_ops", {out_op1[31:0], out_op2[31:0]}, {32'd7, 32'd9});
        chk("bne_wen", 64'(out_rd_wen), 64'd0);

        in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
